load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit_if.sv | 23 ++
 rtl/load_store_unit.sv | 166 ++++++++++++++++
 tb/tb_load_store_unit.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// Request/response handshake bundle between a requester (master) and the load/store unit (slave).
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/load_store_unit.sv
// Big-endian load/store unit in front of a word-only memory; sub-word stores use read-modify-write.
// Define LSU_MISALIGN_TRAP_EN to report misaligned requests as errors instead of force-aligning them.
module load_store_unit #(
    parameter int MEM_BYTES = 128
) (
    input  logic                clk,
    input  logic                rst_n,
    load_store_unit_if.slave    bus,
    output logic [31:0]         mem_addr,
    output logic [31:0]         mem_wdata,
    output logic                mem_read,
    output logic                mem_write,
    input  logic [31:0]         mem_rdata
);
    localparam int AW = $clog2(MEM_BYTES);

    typedef enum logic [2:0] {IDLE, RD, RD_WAIT, WR, RESP} state_t;

    state_t        state;
    state_t        state_next;
    logic [AW-1:0] req_off;
    logic [AW-1:0] addr_q;
    logic [1:0]    size_q;
    logic          write_q;
    logic          unsigned_q;
    logic [31:0]   wdata_q;
    logic [31:0]   rdata_q;
    logic [7:0]    byte_lane;
    logic [15:0]   half_lane;
    logic [31:0]   load_value;
    logic [31:0]   merged;
    logic          unused_addr_bits;

`ifdef LSU_MISALIGN_TRAP_EN
    logic          misaligned;
    logic          err_q;

    assign misaligned = (bus.req_size == 2'b01 && bus.req_addr[0]) ||
                        (bus.req_size[1] && bus.req_addr[1:0] != 2'b00);
`endif

    assign unused_addr_bits = ^bus.req_addr[31:AW];

    // Wrap into the memory and drop the offset bits a half/word access may not carry.
    always_comb begin
        req_off = bus.req_addr[AW-1:0];
        if (bus.req_size[1])
            req_off[1:0] = 2'b00;
        else if (bus.req_size[0])
            req_off[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (bus.req_valid) begin
`ifdef LSU_MISALIGN_TRAP_EN
                    if (misaligned)
                        state_next = RESP;
                    else
`endif
                    if (bus.req_write && bus.req_size[1])
                        state_next = WR;
                    else
                        state_next = RD;
                end
            end
            RD:      state_next = RD_WAIT;
            RD_WAIT: state_next = write_q ? WR : RESP;
            WR:      state_next = IDLE;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Lane 0 is the most significant byte of the memory word.
    always_comb begin
        byte_lane = 8'h00;
        case (addr_q[1:0])
            2'd0: byte_lane = mem_rdata[31:24];
            2'd1: byte_lane = mem_rdata[23:16];
            2'd2: byte_lane = mem_rdata[15:8];
            2'd3: byte_lane = mem_rdata[7:0];
            default: byte_lane = 8'h00;
        endcase
        half_lane = addr_q[1] ? mem_rdata[15:0] : mem_rdata[31:16];

        load_value = mem_rdata;
        case (size_q)
            2'b00: load_value = {{24{~unsigned_q & byte_lane[7]}}, byte_lane};
            2'b01: load_value = {{16{~unsigned_q & half_lane[15]}}, half_lane};
            default: load_value = mem_rdata;
        endcase

        merged = mem_rdata;
        case (size_q)
            2'b00: begin
                case (addr_q[1:0])
                    2'd0: merged[31:24] = wdata_q[7:0];
                    2'd1: merged[23:16] = wdata_q[7:0];
                    2'd2: merged[15:8]  = wdata_q[7:0];
                    2'd3: merged[7:0]   = wdata_q[7:0];
                    default: merged = mem_rdata;
                endcase
            end
            2'b01: begin
                if (addr_q[1])
                    merged[15:0] = wdata_q[15:0];
                else
                    merged[31:16] = wdata_q[15:0];
            end
            default: merged = wdata_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q     <= '0;
            size_q     <= 2'b00;
            write_q    <= 1'b0;
            unsigned_q <= 1'b0;
            wdata_q    <= 32'h0;
            rdata_q    <= 32'h0;
`ifdef LSU_MISALIGN_TRAP_EN
            err_q      <= 1'b0;
`endif
        end else if (state == IDLE && bus.req_valid) begin
            addr_q     <= req_off;
            size_q     <= bus.req_size;
            write_q    <= bus.req_write;
            unsigned_q <= bus.req_unsigned;
            wdata_q    <= bus.req_wdata;
            rdata_q    <= 32'h0;
`ifdef LSU_MISALIGN_TRAP_EN
            err_q      <= misaligned;
`endif
        end else if (state == RD_WAIT) begin
            if (write_q)
                wdata_q <= merged;
            else
                rdata_q <= load_value;
        end
    end

    assign bus.req_ready  = (state == IDLE);
    assign bus.resp_valid = (state == RESP) || (state == WR);
    assign bus.resp_rdata = (state == RESP) ? rdata_q : 32'h0;
`ifdef LSU_MISALIGN_TRAP_EN
    assign bus.resp_err   = (state == RESP) && err_q;
`else
    assign bus.resp_err   = 1'b0;
`endif

    assign mem_read  = (state == RD);
    assign mem_write = (state == WR);
    assign mem_addr  = {{(32-AW){1'b0}}, addr_q[AW-1:2], 2'b00};
    assign mem_wdata = (state == WR) ? wdata_q : 32'h0;
endmodule

// File: tb/tb_load_store_unit.sv
// Randomized self-checking bench for load_store_unit against a byte-array reference model.
module tb_load_store_unit;
    localparam int MEM_BYTES = 128;
    localparam int WORDS     = MEM_BYTES / 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_read;
    logic        mem_write;

    load_store_unit_if bus();

    load_store_unit #(.MEM_BYTES(MEM_BYTES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    logic [31:0] tb_mem [WORDS];
    logic [7:0]  ref_bytes [MEM_BYTES];
    int          compared = 0;
    int          mismatched = 0;
    logic [31:0] last_rdata;
    logic        last_err;

    function automatic int wordIndex(input logic [31:0] a);
        return int'((a >> 2) % WORDS);
    endfunction

    function automatic logic [31:0] refWord(input int base);
        return {ref_bytes[base], ref_bytes[base+1], ref_bytes[base+2], ref_bytes[base+3]};
    endfunction

    // Word memory: registered read on posedge, write on negedge.
    always @(posedge clk) begin
        if (mem_read)
            mem_rdata <= tb_mem[wordIndex(mem_addr)];
    end

    always @(negedge clk) begin
        if (mem_write)
            tb_mem[wordIndex(mem_addr)] <= mem_wdata;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference: memory as big-endian byte array, rules applied directly to bytes.
    task automatic refAccess(input logic wr, input logic [1:0] size, input logic uns,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             output logic [31:0] exp_rdata, output logic exp_err,
                             output int exp_lat, output int exp_reads, output int exp_writes,
                             output int exp_waddr, output logic [31:0] exp_wword);
        int a;
        int n;
        int base;
        logic [31:0] v;
        a = int'(addr % MEM_BYTES);
        n = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
        exp_rdata = 32'h0; exp_err = 1'b0; exp_lat = 3;
        exp_reads = 0; exp_writes = 0; exp_waddr = 0; exp_wword = 32'h0;
`ifdef LSU_MISALIGN_TRAP_EN
        if (a % n != 0) begin
            exp_err = 1'b1;
            exp_lat = 1;
            return;
        end
`endif
        a = a - (a % n);
        base = a - (a % 4);
        if (!wr) begin
            v = 32'h0;
            for (int i = 0; i < n; i++)
                v = (v << 8) | {24'h0, ref_bytes[a+i]};
            if (!uns && n < 4 && v[8*n-1])
                v = v | ~((32'd1 << (8*n)) - 32'd1);
            exp_rdata = v;
            exp_reads = 1;
        end else begin
            for (int i = 0; i < n; i++)
                ref_bytes[a+i] = 8'(wdata >> (8*(n-1-i)));
            exp_lat    = (n == 4) ? 1 : 3;
            exp_reads  = (n == 4) ? 0 : 1;
            exp_writes = 1;
            exp_waddr  = base;
            exp_wword  = refWord(base);
        end
    endtask

    // Drives one request (held until response) and checks timing, memory traffic and result.
    task automatic applyStimulus(input logic wr, input logic [1:0] size, input logic uns,
                                 input logic [31:0] addr, input logic [31:0] wdata);
        logic [31:0] exp_rdata, exp_wword, got_rdata, got_wword, got_waddr;
        logic        exp_err, got_err, got_valid, both, bad_rdata, busy_ready;
        int          exp_lat, exp_reads, exp_writes, exp_waddr;
        int          lat, reads, writes, guard;
        refAccess(wr, size, uns, addr, wdata, exp_rdata, exp_err, exp_lat,
                  exp_reads, exp_writes, exp_waddr, exp_wword);
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_write = wr; bus.req_size = size;
        bus.req_unsigned = uns; bus.req_addr = addr; bus.req_wdata = wdata;
        guard = 0;
        while (!bus.req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("ready_idle", 32'(bus.req_ready), 32'd1);
        @(negedge clk);
        lat = 0; reads = 0; writes = 0; got_valid = 1'b0; both = 1'b0;
        bad_rdata = 1'b0; busy_ready = 1'b0; got_rdata = 32'h0; got_err = 1'b0;
        got_wword = 32'h0; got_waddr = 32'h0;
        for (int c = 1; c <= 6; c++) begin
            if (mem_read) reads++;
            if (mem_write) begin
                writes++;
                got_waddr = mem_addr;
                got_wword = mem_wdata;
            end
            if (mem_read && mem_write) both = 1'b1;
            if (bus.req_ready && !got_valid) busy_ready = 1'b1;
            if (!bus.resp_valid && bus.resp_rdata != 32'h0) bad_rdata = 1'b1;
            if (bus.resp_valid && !got_valid) begin
                got_valid = 1'b1;
                lat = c;
                got_rdata = bus.resp_rdata;
                got_err = bus.resp_err;
                bus.req_valid = 1'b0;
            end
            @(negedge clk);
        end
        bus.req_valid = 1'b0;
        checkOutput("latency", 32'(lat), 32'(exp_lat));
        checkOutput("resp_rdata", got_rdata, exp_rdata);
        checkOutput("resp_err", 32'(got_err), 32'(exp_err));
        checkOutput("mem_reads", 32'(reads), 32'(exp_reads));
        checkOutput("mem_writes", 32'(writes), 32'(exp_writes));
        checkOutput("rd_wr_overlap", 32'(both), 32'd0);
        checkOutput("idle_rdata_zero", 32'(bad_rdata), 32'd0);
        checkOutput("ready_while_busy", 32'(busy_ready), 32'd0);
        if (exp_writes != 0) begin
            checkOutput("write_addr", got_waddr, 32'(exp_waddr));
            checkOutput("write_data", got_wword, exp_wword);
        end
        last_rdata = got_rdata;
        last_err = got_err;
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_ctrl"},
                    32'({bus.req_ready, bus.resp_valid, bus.resp_err, mem_read, mem_write}),
                    32'b10000);
        checkOutput({tag, "_data"}, bus.resp_rdata | mem_addr | mem_wdata, 32'h0);
    endtask

    // Reset lands in the RD_WAIT cycle of a byte store; memory must be untouched.
    task automatic resetMidStore();
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_size = 2'b00;
        bus.req_unsigned = 1'b0; bus.req_addr = 32'h21; bus.req_wdata = 32'h5A;
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkResetOutputs("abort_reset");
        @(negedge clk);
        @(negedge clk);
        checkResetOutputs("abort_hold");
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("abort_ready", 32'(bus.req_ready), 32'd1);
        checkOutput("abort_no_write", 32'(mem_write), 32'd0);
        @(negedge clk);
        checkOutput("abort_mem_word", tb_mem[8], refWord(32));
    endtask

    initial begin
        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_size = 2'b00;
        bus.req_unsigned = 1'b0; bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
        for (int w = 0; w < WORDS; w++) begin
            tb_mem[w] = $urandom();
            {ref_bytes[4*w], ref_bytes[4*w+1], ref_bytes[4*w+2], ref_bytes[4*w+3]} = tb_mem[w];
        end
        repeat (3) @(negedge clk);
        checkResetOutputs("reset");
        rst_n = 1'b1;

        applyStimulus(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        checkOutput("spec_load_word", last_rdata, 32'hDEADBEEF);
        applyStimulus(1'b0, 2'b00, 1'b0, 32'h11, 32'h0);
        checkOutput("spec_byte_signed", last_rdata, 32'hFFFFFFAD);
        applyStimulus(1'b0, 2'b00, 1'b1, 32'h11, 32'h0);
        checkOutput("spec_byte_unsigned", last_rdata, 32'h000000AD);
        applyStimulus(1'b0, 2'b01, 1'b0, 32'h10, 32'h0);
        checkOutput("spec_half_signed", last_rdata, 32'hFFFFDEAD);
        applyStimulus(1'b1, 2'b01, 1'b0, 32'h12, 32'h00001234);
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        checkOutput("spec_rmw_word", last_rdata, 32'hDEAD1234);
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h13, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
        checkOutput("spec_misalign", {last_rdata[31:1], last_err}, 32'h1);
`else
        checkOutput("spec_misalign", {last_rdata[31:1], last_err}, {31'h6F56891A, 1'b0});
`endif
        applyStimulus(1'b1, 2'b10, 1'b0, 32'h84, 32'h0000CAFE);
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h04, 32'h0);
        checkOutput("spec_wrap", last_rdata, 32'h0000CAFE);
        applyStimulus(1'b0, 2'b11, 1'b0, 32'h04, 32'h0);

        resetMidStore();

        for (int t = 0; t < 250; t++) begin
            logic [31:0] a;
            a = ($urandom_range(0, 7) == 0) ? $urandom() : 32'($urandom_range(0, 2*MEM_BYTES-1));
            applyStimulus(1'(($urandom() >> 3) & 1), 2'($urandom_range(0, 3)),
                          1'(($urandom() >> 5) & 1), a, $urandom());
        end

        for (int w = 0; w < WORDS; w++)
            checkOutput("final_mem", tb_mem[w], refWord(4*w));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
